// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: 8x8 unsigned shift-add multiplier with a 2*WIDTH-bit product.
// The loop is controlled by an external shared 8-bit comparator. This block
// supplies the comparator operands, the step counter (cmp_a_o) and WIDTH
// (cmp_b_o), and reads back less/equal to decide whether to iterate or finish.
// A comparator answer that cannot be right ends the operation with err_o set.
// Optional feature: define EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero. Latency then depends on the operand.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [7:0]         cmp_a_o,
    output logic [7:0]         cmp_b_o,
    input  logic               cmp_less_i,
    input  logic               cmp_equal_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               err_q;

    // Control strobes from the FSM to the datapath.
    logic accept;
    logic do_step;
    logic finish;
    logic set_err;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers are assigned with <= so every flop samples values from before the edge.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes. Priority inside CALC is: flush,
    // then early termination (if enabled), then the comparator decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        do_step = 1'b0;
        finish  = 1'b0;
        set_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush_i && start_i) begin
                    accept  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
`ifdef EARLY_TERM_EN
                end else if (mplier_q == '0) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
`endif
                end else if (cmp_less_i && cmp_equal_i) begin
                    // Both flags at once is impossible. Stop without stepping.
                    finish  = 1'b1;
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end else if (cmp_less_i) begin
                    do_step = 1'b1;
                end else if (cmp_equal_i) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    // The counter is past WIDTH, so the comparator or the counter is faulty.
                    finish  = 1'b1;
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add step, and result/error capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, a_i};
                mplier_q <= b_i;
                acc_q    <= '0;
                count_q  <= '0;
                err_q    <= 1'b0;
            end
            if (do_step) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + 8'd1;
            end
            if (finish) begin
                product_q <= acc_q;
                if (set_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // The comparator operands come only from registers and constants. No path
    // runs from cmp_*_i back to cmp_*_o.
    assign cmp_a_o   = count_q;
    assign cmp_b_o   = 8'(WIDTH);
    assign ready_o   = (state_q == ST_IDLE);
    assign valid_o   = (state_q == ST_DONE);
    assign err_o     = valid_o & err_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl. The bench models the shared comparator,
// and a fault override can corrupt it. Expected results go into a scoreboard
// queue when an operation is issued and are taken out when valid_o appears.
// Honours EARLY_TERM_EN for the expected latencies.
module tb_seq_mult_ctrl;

    localparam int WIDTH = 8;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic               flush_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic [7:0]         cmp_a_o;
    logic [7:0]         cmp_b_o;
    logic               cmp_less_i;
    logic               cmp_equal_i;
    logic               ready_o;
    logic               valid_o;
    logic [2*WIDTH-1:0] product_o;
    logic               err_o;
    logic               force_bad;

    seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cmp_a_o     (cmp_a_o),
        .cmp_b_o     (cmp_b_o),
        .cmp_less_i  (cmp_less_i),
        .cmp_equal_i (cmp_equal_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .product_o   (product_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Comparator model. force_bad makes it report neither less nor equal.
    assign cmp_less_i  = force_bad ? 1'b0 : (cmp_a_o <  cmp_b_o);
    assign cmp_equal_i = force_bad ? 1'b0 : (cmp_a_o == cmp_b_o);

    typedef struct {
        logic [15:0] product;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected number of edges from accept to the edge that raises valid_o.
    function automatic int exp_lat(input logic [7:0] b);
        int hb = -1;
        for (int i = 0; i < 8; i++) if (b[i]) hb = i;
`ifdef EARLY_TERM_EN
        return hb + 2;
`else
        hb = WIDTH + 1;
        return hb;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        edges++;
    endtask

    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        edges   = 0;
    endtask

    task automatic wait_count(input string tag, input int n);
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (cmp_a_o == 8'(n)) hit = 1'b1;
        end
        check({tag, " count reached"}, 32'(hit), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"},   32'(ready_o),   32'd1);
        check({tag, " valid"},   32'(valid_o),   32'd0);
        check({tag, " product"}, 32'(product_o), 32'd0);
        check({tag, " err"},     32'(err_o),     32'd0);
        check({tag, " cmp_a"},   32'(cmp_a_o),   32'd0);
        check({tag, " cmp_b"},   32'(cmp_b_o),   32'(WIDTH));
    endtask

    // Waits a bounded time for valid_o, then compares against the scoreboard head.
    task automatic wait_result(input string tag);
        bit   seen   = 1'b0;
        bit   rdy_hi = 1'b0;
        exp_t e;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (valid_o) seen = 1'b1;
            else if (ready_o) rdy_hi = 1'b1;
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
        check({tag, " scoreboard nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, " latency"}, 32'(edges),     32'(e.lat));
                check({tag, " product"}, 32'(product_o), 32'(e.product));
                check({tag, " err"},     32'(err_o),     32'(e.err));
                check({tag, " ready low during op"}, 32'(rdy_hi), 32'd0);
            end
        end
        tick();
        check({tag, " valid one cycle"}, 32'(valid_o), 32'd0);
        check({tag, " ready after"},     32'(ready_o), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.product = 16'(a) * 16'(b);
        e.err     = 1'b0;
        e.lat     = exp_lat(b);
        sb.push_back(e);
        check({tag, " ready before"}, 32'(ready_o), 32'd1);
        accept_op(a, b);
        wait_result(tag);
    endtask

    initial begin
        exp_t e;
        bit   any_valid;
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        flush_i   = 1'b0;
        a_i       = '0;
        b_i       = '0;
        force_bad = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Main function across several operand patterns.
        run_op("T1", 8'hFF, 8'hFF);
        run_op("T2", 8'd13, 8'd11);
        run_op("T3", 8'h5A, 8'h00);
        run_op("msb_a", 8'h80, 8'h01);
        run_op("msb_b", 8'h01, 8'h80);
        run_op("zero_a", 8'h00, 8'hFF);
        run_op("T2b", 8'd13, 8'd11);

        // T4: a start during CALC is ignored, then a flush aborts the operation.
        check("T4 ready before", 32'(ready_o), 32'd1);
        accept_op(8'h21, 8'h37);
        wait_count("T4 c3", 3);
        start_i = 1'b1;
        a_i     = 8'h77;
        b_i     = 8'h66;
        tick();
        start_i = 1'b0;
        wait_count("T4 c5", 5);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("T4 ready after flush", 32'(ready_o),   32'd1);
        check("T4 no valid",          32'(valid_o),   32'd0);
        check("T4 product held",      32'(product_o), 32'h008F);
        // A flush together with a start in IDLE wins, so nothing is accepted.
        @(negedge clk_i);
        start_i = 1'b1;
        flush_i = 1'b1;
        a_i     = 8'h05;
        b_i     = 8'h07;
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush+start ready", 32'(ready_o), 32'd1);
        any_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o) any_valid = 1'b1;
        end
        check("T4 no queued op", 32'(any_valid), 32'd0);
        check("T4 product still held", 32'(product_o), 32'h008F);

        // T5: an asynchronous reset in the middle of an operation.
        accept_op(8'd13, 8'd11);
        wait_count("T5 c4", 4);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("T5");
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op("T5 rerun", 8'd13, 8'd11);

        // T6: the comparator reports neither less nor equal at count 3.
        e.product = 16'h012C;
        e.err     = 1'b1;
        e.lat     = 4;
        sb.push_back(e);
        check("T6 ready before", 32'(ready_o), 32'd1);
        accept_op(8'h3C, 8'hB5);
        wait_count("T6 c3", 3);
        force_bad = 1'b1;
        wait_result("T6");
        force_bad = 1'b0;

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
